// File: rtl/cpu_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and memories.
interface cpu_sequencer_if #(
  parameter int PC_W = 10
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [8:0]      imem_data;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_data, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_data, dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 9-bit CPU: owns pc, IR and the
// retired counter, drives memory handshakes and one-cycle execute strobes.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem_req held with imem_addr=pc until imem_ack
// DECODE | one cycle, route load/stor to MEM, everything else to EXEC
// EXEC   | ctl_exec strobe, pc update and retire
// MEM    | dmem_req held until dmem_ack
// WB     | load write-back strobe, pc update and retire
// HALT   | stopped after func done, start resumes at pc
module cpu_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  cpu_sequencer_if.master  mem,
  input  logic             zero_flag,
  input  logic [PC_W-1:0]  jmp_target,
  output logic [4:0]       ctl_op,
  output logic [3:0]       ctl_field,
  output logic             ctl_exec,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output logic             halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [4:0] OP_LOAD = 5'd16;
  localparam logic [4:0] OP_STOR = 5'd17;
  localparam logic [4:0] OP_JIZR = 5'd20;
  localparam logic [4:0] OP_JNZR = 5'd21;
  localparam logic [4:0] OP_BIZR = 5'd22;
  localparam logic [4:0] OP_BNZR = 5'd23;
  localparam logic [4:0] OP_ZZZZ = 5'd24;
  localparam logic [4:0] OP_FUNC = 5'd31;
  localparam logic [3:0] FN_DONE = 4'd15;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]      state;
  logic [8:0]      ir;
  logic [4:0]      op;
  logic [3:0]      field;
  logic            is_mem_op;
  logic            is_jump;
  logic            is_branch;
  logic            cond_met;
  logic            writes_rf;
  logic            is_done;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] exec_pc;

  assign op    = ir[8:4];
  assign field = ir[3:0];

  // Decode the latched instruction and pick the pc for the end of EXEC.
  always_comb begin
    is_mem_op = (op == OP_LOAD) || (op == OP_STOR);
    is_jump   = (op == OP_JIZR) || (op == OP_JNZR);
    is_branch = (op == OP_BIZR) || (op == OP_BNZR);
    is_done   = (op == OP_FUNC) && (field == FN_DONE);
    // jizr/bizr take on zero, jnzr/bnzr on non-zero.
    cond_met  = ((op == OP_JIZR) || (op == OP_BIZR)) ? zero_flag : ~zero_flag;
    // Anything that is not control flow, memory, nop or func writes a register.
    writes_rf = !(is_mem_op || is_jump || is_branch ||
                  (op == OP_ZZZZ) || (op == OP_FUNC));
    pc_inc    = pc + PC_ONE;
    pc_rel    = pc + {{(PC_W-4){field[3]}}, field};
    exec_pc   = pc_inc;
    if (is_jump && cond_met) begin
      exec_pc = jmp_target;
    end else if (is_branch && cond_met) begin
      exec_pc = pc_rel;
    end
  end

  // Sequencer state, pc, IR and retired counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.imem_ack) begin
            ir    <= mem.imem_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= is_mem_op ? S_MEM : S_EXEC;
        end
        S_EXEC: begin
          pc      <= exec_pc;
          retired <= retired + CNT_ONE;
          state   <= is_done ? S_HALT : S_FETCH;
        end
        S_MEM: begin
          if (mem.dmem_ack) begin
            if (op == OP_STOR) begin
              pc      <= pc_inc;
              retired <= retired + CNT_ONE;
              state   <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc      <= pc_inc;
          retired <= retired + CNT_ONE;
          state   <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state and the latched instruction.
  always_comb begin
    mem.imem_req  = (state == S_FETCH);
    mem.imem_addr = pc;
    mem.dmem_req  = (state == S_MEM);
    mem.dmem_we   = (state == S_MEM) && (op == OP_STOR);
    ctl_op        = op;
    ctl_field     = field;
    ctl_exec      = (state == S_EXEC) || (state == S_WB);
    rf_we         = ((state == S_EXEC) && writes_rf) || (state == S_WB);
    busy          = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
    halted        = (state == S_HALT);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a table of single instructions run
// back to back through a responding memory model, plus hand sequences for
// reset, halt/resume and reset in the middle of a data access.
module tb_cpu_sequencer;

  typedef struct {
    logic [8:0] instr;
    logic       zf;
    logic [9:0] jt;
    int         idly;
    int         ddly;
    logic [9:0] fpc;
    logic [9:0] epc;
    int         rf;
    int         ex;
    int         cyc;
    int         dreq;
    int         dwe;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        zero_flag;
  logic [9:0]  jmp_target;
  logic [4:0]  ctl_op;
  logic [3:0]  ctl_field;
  logic        ctl_exec;
  logic        rf_we;
  logic [9:0]  pc;
  logic [15:0] retired;
  logic        busy;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_ret  = 0;
  vec_t        vecs[23];
  vec_t        exp_q[$];

  cpu_sequencer_if #(.PC_W(10)) mem_if ();

  cpu_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem        (mem_if.master),
    .zero_flag  (zero_flag),
    .jmp_target (jmp_target),
    .ctl_op     (ctl_op),
    .ctl_field  (ctl_field),
    .ctl_exec   (ctl_exec),
    .rf_we      (rf_we),
    .pc         (pc),
    .retired    (retired),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH; returns at the
  // negedge where retired has moved on.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc = 0, rf = 0, ex = 0, ireq = 0, dreq = 0, dwe = 0;
    int   addr_bad = 0, op_bad = 0, iw = 0, dw = 0;
    bit   done = 0;
    logic [15:0] r0;
    vec_t e;
    r0 = retired;
    zero_flag  = v.zf;
    jmp_target = v.jt;
    exp_q.push_back(v);
    while (!done) begin
      if (retired !== r0) begin
        done = 1;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
      end else if (cyc >= 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout vec %0d: got %0d cycles, expected %0d", idx, cyc, v.cyc);
        done = 1;
      end else begin
        cyc++;
        if (ctl_exec) begin
          ex++;
          if ({ctl_op, ctl_field} !== v.instr) op_bad++;
        end
        if (rf_we) rf++;
        mem_if.imem_ack  = 1'b0;
        mem_if.imem_data = 9'h0AA;
        mem_if.dmem_ack  = 1'b0;
        if (mem_if.imem_req) begin
          ireq++;
          if (mem_if.imem_addr !== v.fpc) addr_bad++;
          if (iw == v.idly) begin
            mem_if.imem_ack  = 1'b1;
            mem_if.imem_data = v.instr;
          end else begin
            iw++;
          end
        end
        if (mem_if.dmem_req) begin
          dreq++;
          if (mem_if.dmem_we) dwe++;
          if (dw == v.ddly) mem_if.dmem_ack = 1'b1;
          else dw++;
        end
        @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    exp_ret++;
    check($sformatf("v%0d pc", idx), pc, e.epc);
    check($sformatf("v%0d retired", idx), retired, exp_ret);
    check($sformatf("v%0d cycles", idx), cyc, e.cyc);
    check($sformatf("v%0d rf_we", idx), rf, e.rf);
    check($sformatf("v%0d ctl_exec", idx), ex, e.ex);
    check($sformatf("v%0d imem_req", idx), ireq, e.idly + 1);
    check($sformatf("v%0d dmem_req", idx), dreq, e.dreq);
    check($sformatf("v%0d dmem_we", idx), dwe, e.dwe);
    check($sformatf("v%0d addr_bad", idx), addr_bad, 0);
    check($sformatf("v%0d op_bad", idx), op_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr   zf    jt       idly ddly fpc      epc      rf ex cyc dreq dwe
    vecs[0]  = '{9'h020, 1'b0, 10'h000, 0, 0, 10'h000, 10'h001, 1, 1, 3, 0, 0};
    vecs[1]  = '{9'h020, 1'b0, 10'h000, 4, 0, 10'h001, 10'h002, 1, 1, 7, 0, 0};
    vecs[2]  = '{9'h033, 1'b0, 10'h000, 0, 0, 10'h002, 10'h003, 1, 1, 3, 0, 0};
    vecs[3]  = '{9'h040, 1'b1, 10'h000, 0, 0, 10'h003, 10'h004, 1, 1, 3, 0, 0};
    vecs[4]  = '{9'h180, 1'b0, 10'h000, 0, 0, 10'h004, 10'h005, 0, 1, 3, 0, 0};
    vecs[5]  = '{9'h16E, 1'b1, 10'h000, 0, 0, 10'h005, 10'h003, 0, 1, 3, 0, 0};
    vecs[6]  = '{9'h180, 1'b0, 10'h000, 0, 0, 10'h003, 10'h004, 0, 1, 3, 0, 0};
    vecs[7]  = '{9'h180, 1'b0, 10'h000, 0, 0, 10'h004, 10'h005, 0, 1, 3, 0, 0};
    vecs[8]  = '{9'h16E, 1'b0, 10'h000, 0, 0, 10'h005, 10'h006, 0, 1, 3, 0, 0};
    vecs[9]  = '{9'h176, 1'b0, 10'h000, 0, 0, 10'h006, 10'h00C, 0, 1, 3, 0, 0};
    vecs[10] = '{9'h140, 1'b0, 10'h3FF, 0, 0, 10'h00C, 10'h00D, 0, 1, 3, 0, 0};
    vecs[11] = '{9'h150, 1'b1, 10'h3FF, 0, 0, 10'h00D, 10'h00E, 0, 1, 3, 0, 0};
    vecs[12] = '{9'h140, 1'b1, 10'h3FF, 0, 0, 10'h00E, 10'h3FF, 0, 1, 3, 0, 0};
    vecs[13] = '{9'h180, 1'b0, 10'h000, 0, 0, 10'h3FF, 10'h000, 0, 1, 3, 0, 0};
    vecs[14] = '{9'h168, 1'b1, 10'h000, 0, 0, 10'h000, 10'h3F8, 0, 1, 3, 0, 0};
    vecs[15] = '{9'h150, 1'b0, 10'h02A, 0, 0, 10'h3F8, 10'h02A, 0, 1, 3, 0, 0};
    vecs[16] = '{9'h100, 1'b0, 10'h000, 0, 2, 10'h02A, 10'h02B, 1, 1, 6, 3, 0};
    vecs[17] = '{9'h110, 1'b0, 10'h000, 0, 0, 10'h02B, 10'h02C, 0, 0, 3, 1, 1};
    vecs[18] = '{9'h1F3, 1'b0, 10'h000, 0, 0, 10'h02C, 10'h02D, 0, 1, 3, 0, 0};
    vecs[19] = '{9'h177, 1'b1, 10'h000, 0, 0, 10'h02D, 10'h02E, 0, 1, 3, 0, 0};
    vecs[20] = '{9'h0A5, 1'b0, 10'h000, 0, 0, 10'h02E, 10'h02F, 1, 1, 3, 0, 0};
    vecs[21] = '{9'h1FF, 1'b0, 10'h000, 0, 0, 10'h02F, 10'h030, 0, 1, 3, 0, 0};
    vecs[22] = '{9'h180, 1'b0, 10'h000, 0, 0, 10'h030, 10'h031, 0, 1, 3, 0, 0};

    reset = 1'b1;
    start = 1'b0;
    zero_flag = 1'b0;
    jmp_target = '0;
    mem_if.imem_ack  = 1'b0;
    mem_if.imem_data = '0;
    mem_if.dmem_ack  = 1'b0;

    @(negedge clk);
    check("reset pc", pc, 0);
    check("reset retired", retired, 0);
    check("reset outputs", {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we,
                            ctl_exec, rf_we, busy, halted, ctl_op, ctl_field}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle without start", {busy, mem_if.imem_req}, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy after start", busy, 1);

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    check("halted after done", {halted, busy, mem_if.imem_req}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    check("halt holds pc", pc, 10'h030);
    check("halt no fetch", {halted, mem_if.imem_req}, 2'b10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("resume fetch", {halted, busy, mem_if.imem_req}, 3'b011);
    run_vec(vecs[22], 22);

    // Load that gets reset while its data access is outstanding.
    mem_if.imem_ack  = 1'b1;
    mem_if.imem_data = 9'h100;
    @(negedge clk);
    mem_if.imem_ack = 1'b0;
    @(negedge clk);
    check("mem before reset", {mem_if.dmem_req, mem_if.dmem_we}, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    check("reset drops dmem_req", mem_if.dmem_req, 0);
    check("reset in mem pc", pc, 0);
    check("reset in mem retired", retired, 0);
    check("reset in mem state", {busy, halted, ctl_exec, rf_we}, 0);
    mem_if.dmem_ack = 1'b1;
    mem_if.imem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stale ack ignored", {busy, mem_if.imem_req, mem_if.dmem_req, rf_we}, 0);
    check("stale ack pc", pc, 0);
    check("stale ack retired", retired, 0);
    mem_if.dmem_ack = 1'b0;
    mem_if.imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
